// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: paces ADC samples from a small FIFO into the time-multiplexed
// FIR filter and captures each filter result a fixed latency after its strobe.
// Optional build macro FEEDER_ZERO_STUFF_EN: underrun ticks issue a zero sample
// so the filter cadence never breaks.
module fir_sample_feeder #(
    parameter int unsigned N       = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_GAP = 8,
    parameter int unsigned RES_LAT = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [15:0]  div,
    input  logic         s_valid,
    input  logic [N-1:0] s_data,
    output logic         s_ready,
    output logic         fir_en,
    output logic [N-1:0] fir_x,
    input  logic [N-1:0] fir_y,
    output logic         y_valid,
    output logic [N-1:0] y_data,
    output logic [7:0]   underrun_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = $clog2(RES_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } cap_state_t;

    logic [DW-1:0] eff_div;
    logic [DW-1:0] reload;
    logic [DW-1:0] cnt;
    logic          tick;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_next;
    logic          empty;
    logic          push;
    logic          pop;
    logic          issue;

    cap_state_t    state;
    cap_state_t    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          capture_c;

    // Effective period clamps short divisors so strobes never outrun the filter
    always_comb begin
        eff_div = (div < DW'(MIN_GAP)) ? DW'(MIN_GAP) : div;
        reload  = eff_div - DW'(1);
    end

    // Period counter: held at reload while paused, reloads after each tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= reload;
        end else if (!run) begin
            cnt <= reload;
        end else if (cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - DW'(1);
        end
    end

    // Tick, FIFO handshake and issue decisions
    always_comb begin
        tick  = run && (cnt == '0);
        empty = (occ == '0);
        push  = s_valid && s_ready;
        pop   = tick && !empty;
`ifdef FEEDER_ZERO_STUFF_EN
        issue = tick;
`else
        issue = pop;
`endif
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OW'(1);
            2'b01:   occ_next = occ - OW'(1);
            default: occ_next = occ;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ     <= occ_next;
            s_ready <= (occ_next != OW'(DEPTH));
        end
    end

    // Filter strobe and sample register; sample holds between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            fir_en <= 1'b0;
            fir_x  <= '0;
        end else begin
            fir_en <= issue;
            if (pop) begin
                fir_x <= mem[rd_ptr];
            end else if (issue) begin
                fir_x <= '0;
            end
        end
    end

    // Saturating underrun counter
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (tick && empty && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Capture FSM next state; triggered by the strobe as it is registered,
    // so DONE lines up exactly RES_LAT cycles after fir_en is seen
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_next = S_WAIT;
                    timer_next = TW'(RES_LAT - 1);
                end
            end
            S_WAIT: begin
                if (issue) begin
                    timer_next = TW'(RES_LAT - 1);
                end else if (timer == '0) begin
                    state_next = S_DONE;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_DONE: begin
                if (issue) begin
                    state_next = S_WAIT;
                    timer_next = TW'(RES_LAT - 1);
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Capture FSM outputs
    always_comb begin
        y_valid   = (state == S_DONE);
        capture_c = (state == S_WAIT) && (timer == '0) && !issue;
    end

    // Result register loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            y_data <= '0;
        end else if (capture_c) begin
            y_data <= fir_y;
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Testbench for fir_sample_feeder: directed period table, corner sequences and
// randomized traffic checked every cycle against a queue/schedule model.
module tb_fir_sample_feeder;

    localparam int N       = 16;
    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 8;
    localparam int RES_LAT = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [15:0]  div;
    logic         s_valid;
    logic [N-1:0] s_data;
    logic         s_ready;
    logic         fir_en;
    logic [N-1:0] fir_x;
    logic [N-1:0] fir_y;
    logic         y_valid;
    logic [N-1:0] y_data;
    logic [7:0]   underrun_cnt;

    fir_sample_feeder #(.N(N), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .RES_LAT(RES_LAT)) dut (
        .clk(clk), .rst(rst), .run(run), .div(div),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fir_en(fir_en), .fir_x(fir_x), .fir_y(fir_y),
        .y_valid(y_valid), .y_data(y_data), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sample queue plus absolute-time tick schedule
    int           cyc = 0;
    int           next_tick = 0;
    int           cap_due = -1;
    int           ucnt = 0;
    logic [N-1:0] q[$];
    logic         e_s_ready = 1'b1;
    logic         e_fir_en = 1'b0;
    logic [N-1:0] e_fir_x = '0;
    logic         e_y_valid = 1'b0;
    logic [N-1:0] e_y_data = '0;

    typedef struct {
        logic [15:0] div;
        int          gap;
    } vec_t;
    vec_t vecs[6];

    logic [N-1:0] samples[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int  eff;
        bit  tick;
        bit  acc;
        eff = (int'(div) < MIN_GAP) ? MIN_GAP : int'(div);
        if (rst) begin
            q.delete();
            next_tick = cyc + eff;
            cap_due   = -1;
            ucnt      = 0;
            e_fir_en  = 1'b0;
            e_fir_x   = '0;
            e_y_valid = 1'b0;
            e_y_data  = '0;
            e_s_ready = 1'b1;
        end else begin
            acc  = s_valid && (q.size() < DEPTH);
            tick = run && (cyc == next_tick);
            if (!run || tick) next_tick = cyc + eff;
            e_y_valid = (cap_due == cyc + 1);
            if (e_y_valid) e_y_data = fir_y;
            e_fir_en = 1'b0;
            if (tick) begin
                if (q.size() > 0) begin
                    e_fir_en = 1'b1;
                    e_fir_x  = q.pop_front();
                end else begin
                    if (ucnt < 255) ucnt++;
`ifdef FEEDER_ZERO_STUFF_EN
                    e_fir_en = 1'b1;
                    e_fir_x  = '0;
`endif
                end
            end
            if (acc) q.push_back(s_data);
            if (e_fir_en) cap_due = cyc + 1 + RES_LAT;
            e_s_ready = (q.size() < DEPTH);
        end
        cyc++;
    endtask

    // One clock: advance model on the edge, compare just after it, new fir_y
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("s_ready", 32'(s_ready), 32'(e_s_ready));
        check("fir_en", 32'(fir_en), 32'(e_fir_en));
        check("fir_x", 32'(fir_x), 32'(e_fir_x));
        check("y_valid", 32'(y_valid), 32'(e_y_valid));
        check("y_data", 32'(y_data), 32'(e_y_data));
        check("underrun_cnt", 32'(underrun_cnt), 32'(ucnt));
        fir_y = N'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; s_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [N-1:0] v, input int budget);
        bit acc;
        bit done;
        done = 0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < budget && !done; i++) begin
            acc = e_s_ready;
            cycle();
            if (acc) done = 1;
        end
        s_valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_en(input int budget, output int c);
        bit seen;
        seen = 0;
        c = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (fir_en === 1'b1) begin
                seen = 1;
                c = cyc;
            end
        end
        check("fir_en_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, nseen, yv_c, en_c, acc_c, pulses;
        int en_cyc[3];
        logic [N-1:0] xs[5];
        bit acc, yv_seen;

        vecs[0] = '{16'd10, 10};
        vecs[1] = '{16'd3,  8};
        vecs[2] = '{16'd0,  8};
        vecs[3] = '{16'd8,  8};
        vecs[4] = '{16'd9,  9};
        vecs[5] = '{16'd13, 13};
        samples[0] = 16'h1000;
        samples[1] = 16'h2000;
        samples[2] = 16'h7FFF;

        rst = 1'b1; run = 1'b0; div = 16'd10; s_valid = 1'b0; s_data = '0; fir_y = '0;

        // Reset state
        do_reset();
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_fir_en", 32'(fir_en), 32'd0);

        // Period table: strobe delay after run rises and spacing, sample order
        for (int i = 0; i < 6; i++) begin
            do_reset();
            div = vecs[i].div;
            for (int k = 0; k < 3; k++) push_one(samples[k], 4);
            run = 1'b1;
            t = cyc;
            nseen = 0;
            for (int j = 0; j < 4 * vecs[i].gap + 20 && nseen < 3; j++) begin
                cycle();
                if (fir_en === 1'b1) begin
                    en_cyc[nseen] = cyc;
                    xs[nseen] = fir_x;
                    nseen++;
                end
            end
            check("vec_strobes", 32'(nseen), 32'd3);
            if (nseen > 0) check("vec_first_delay", 32'(en_cyc[0] - t), 32'(vecs[i].gap));
            for (int k = 1; k < nseen; k++)
                check("vec_spacing", 32'(en_cyc[k] - en_cyc[k-1]), 32'(vecs[i].gap));
            for (int k = 0; k < nseen; k++)
                check("vec_order", 32'(xs[k]), 32'(samples[k]));
            run = 1'b0;
            for (int j = 0; j < RES_LAT + 2; j++) cycle();
        end

        // FIFO full with run=0, fifth sample waits for the first pop
        do_reset();
        div = 16'd0;
        for (int k = 1; k <= 4; k++) push_one(N'(k), 4);
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = N'(5);
        run = 1'b1;
        nseen = 0; acc_c = -1; en_c = -1;
        for (int j = 0; j < 80 && nseen < 5; j++) begin
            acc = e_s_ready && s_valid;
            if (acc) acc_c = cyc;
            cycle();
            if (acc) s_valid = 1'b0;
            if (fir_en === 1'b1) begin
                if (nseen == 0) en_c = cyc;
                xs[nseen] = fir_x;
                nseen++;
            end
        end
        check("full_strobes", 32'(nseen), 32'd5);
        check("full_fifth_after_pop", 32'(acc_c >= en_c && en_c >= 0), 32'd1);
        for (int k = 0; k < nseen; k++) check("full_order", 32'(xs[k]), 32'(k + 1));

        // Empty FIFO for 300 ticks: counter saturates
        do_reset();
        div = 16'd0;
        run = 1'b1;
        pulses = 0;
        for (int j = 0; j < 300 * MIN_GAP; j++) begin
            cycle();
            if (fir_en === 1'b1) pulses++;
        end
        check("underrun_sat", 32'(underrun_cnt), 32'd255);
`ifdef FEEDER_ZERO_STUFF_EN
        check("underrun_pulses", 32'(pulses), 32'd300);
`else
        check("underrun_pulses", 32'(pulses), 32'd0);
`endif

        // Reset two cycles after a strobe aborts the capture
        do_reset();
        div = 16'd0;
        push_one(16'h1234, 4);
        run = 1'b1;
        wait_en(20, c);
        cycle();
        cycle();
        rst = 1'b1; run = 1'b0;
        cycle();
        rst = 1'b0;
        yv_seen = 0;
        for (int j = 0; j < RES_LAT + 4; j++) begin
            cycle();
            if (y_valid === 1'b1) yv_seen = 1;
        end
        check("rst_abort_no_yvalid", 32'(yv_seen), 32'd0);
        check("rst_abort_s_ready", 32'(s_ready), 32'd1);
        check("rst_abort_fir_x", 32'(fir_x), 32'd0);

        // Pause two cycles after a strobe: capture completes, pacing restarts
        do_reset();
        div = 16'd10;
        push_one(16'h0AAA, 4);
        push_one(16'h0BBB, 4);
        run = 1'b1;
        wait_en(20, c);
        cycle();
        cycle();
        run = 1'b0;
        yv_c = -1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            if (y_valid === 1'b1) yv_c = cyc;
        end
        run = 1'b1;
        t = cyc;
        en_c = -1;
        for (int j = 0; j < 15 && en_c < 0; j++) begin
            cycle();
            if (y_valid === 1'b1) yv_c = cyc;
            if (fir_en === 1'b1) en_c = cyc;
        end
        check("pause_yvalid_lat", 32'(yv_c - c), 32'(RES_LAT));
        check("pause_restart_gap", 32'(en_c - t), 32'd10);

        // Randomized traffic against the model
        do_reset();
        div = 16'd9;
        for (int j = 0; j < 3000; j++) begin
            rst = ($urandom_range(0, 299) == 0);
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 14));
            s_valid = ($urandom_range(0, 2) == 0);
            s_data  = N'($urandom);
            cycle();
        end
        rst = 1'b0; run = 1'b0; s_valid = 1'b0;
        for (int j = 0; j < RES_LAT + 2; j++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
